result_collector: RTL and testbench

Downstream stage of the x→y processing unit: watches the unit's `active` output and, on every completed operation (`active` falling), captures the final `y`, `s`, `b` and `regime` into a small FIFO. Results are drained by a consumer through a valid/ready handshake, which decouples result pickup from the processing unit's timing. Dropped results are reported by a sticky overflow flag.

---
 rtl/result_collector.sv | 213 +++++++++++++++++++++
 tb/tb_result_collector.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/result_collector.sv
// result_collector: captures {regime, b, s, y} from the processing unit each
// time its `active` output falls, and queues the results in a small circular
// FIFO drained through a valid/ready handshake. Drops while full raise a
// sticky overflow flag.
// Optional feature macro: RESULT_COLLECTOR_COUNT_EN adds the `done_cnt`
// output, a saturating 8-bit count of all completions (dropped ones included).
module result_collector #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               y,
  input  logic [2:0]               s,
  input  logic                     b,
  input  logic [1:0]               regime,
  input  logic                     active,
  output logic                     r_valid,
  input  logic                     r_ready,
  output logic [13:0]              r_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow,
`ifdef RESULT_COLLECTOR_COUNT_EN
  output logic [7:0]               done_cnt,
`endif
  input  logic                     clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Per-slot occupancy tracked as a tiny two-state machine per entry.
  typedef enum logic {
    FREE   = 1'b0,
    STORED = 1'b1
  } entry_state_t;

  // Storage is a plain array so it can map onto distributed/block RAM.
  logic [13:0]     mem [DEPTH];

  logic            active_d_reg;
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   wr_ptr_next;
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW-1:0]   rd_ptr_next;
  logic [CW-1:0]   count_reg;
  logic [CW-1:0]   count_next;
  logic            overflow_reg;
  logic            overflow_next;
  logic [13:0]     r_data_reg;
  logic [DEPTH-1:0] entry_stored;

  logic            completion;
  logic            pop;
  logic            push_ok;
  logic            drop;
  logic            full_int;
  logic [13:0]     entry;

  // Result word as presented to the consumer.
  assign entry      = {regime, b, s, y};

  // A completion is the falling edge of the processing unit's busy flag.
  assign completion = active_d_reg && !active;

  assign full_int   = (count_reg == CW'(DEPTH));

  // r_valid follows the occupancy of the head slot, so a pop is only
  // possible when something is stored.
  assign r_valid    = entry_stored[rd_ptr_reg];
  assign pop        = r_valid && r_ready;

  // When full, a same-cycle pop frees the slot the push needs.
  assign push_ok    = completion && (!full_int || pop);
  assign drop       = completion && full_int && !pop;

  // Previous value of `active` for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_d_reg <= 1'b0;
    end else begin
      active_d_reg <= active;
    end
  end

  // Next-state logic for pointers, occupancy count and the sticky flag.
  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;

    if (push_ok) begin
      wr_ptr_next = wr_ptr_reg + AW'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + AW'(1);
    end

    case ({push_ok, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase

    // A drop in the same cycle as a clear leaves the flag set.
    if (drop) begin
      overflow_next = 1'b1;
    end else if (clr_ovf) begin
      overflow_next = 1'b0;
    end
  end

  // Pointer, count and overflow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
    end
  end

  // Result storage write port; contents need no reset since occupancy
  // is tracked separately.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= entry;
    end
  end

  // Registered head-of-queue read. The read address is the head for the
  // next cycle; if that slot is being written right now the incoming entry
  // is forwarded, which covers push-into-empty and push+pop at one entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_reg <= '0;
    end else if (push_ok && (wr_ptr_reg == rd_ptr_next)) begin
      r_data_reg <= entry;
    end else begin
      r_data_reg <= mem[rd_ptr_next];
    end
  end

  // One FREE/STORED state machine per slot.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      entry_state_t state_reg;
      entry_state_t state_next;
      logic         wr_hit;
      logic         rd_hit;

      assign wr_hit = push_ok && (wr_ptr_reg == AW'(gi));
      assign rd_hit = pop && (rd_ptr_reg == AW'(gi));

      // Slot state register.
      always_ff @(posedge clk) begin
        if (rst) begin
          state_reg <= FREE;
        end else begin
          state_reg <= state_next;
        end
      end

      // Slot transitions; a refill on the same edge as its pop keeps it STORED.
      always_comb begin
        state_next = state_reg;
        case (state_reg)
          FREE: begin
            if (wr_hit) begin
              state_next = STORED;
            end
          end
          STORED: begin
            if (rd_hit && !wr_hit) begin
              state_next = FREE;
            end
          end
          default: state_next = FREE;
        endcase
      end

      assign entry_stored[gi] = (state_reg == STORED);
    end
  endgenerate

`ifdef RESULT_COLLECTOR_COUNT_EN
  logic [7:0] done_cnt_reg;

  // Saturating count of every completion, accepted or dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_cnt_reg <= 8'd0;
    end else if (completion && (done_cnt_reg != 8'hFF)) begin
      done_cnt_reg <= done_cnt_reg + 8'd1;
    end
  end

  assign done_cnt = done_cnt_reg;
`endif

  assign r_data   = r_data_reg;
  assign count    = count_reg;
  assign full     = full_int;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_result_collector.sv
// Self-checking bench for result_collector: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_result_collector;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  y;
  logic [2:0]  s;
  logic        b;
  logic [1:0]  regime;
  logic        active;
  logic        r_valid;
  logic        r_ready;
  logic [13:0] r_data;
  logic [2:0]  count;
  logic        full;
  logic        overflow;
  logic        clr_ovf;
`ifdef RESULT_COLLECTOR_COUNT_EN
  logic [7:0]  done_cnt;
`endif

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  logic [13:0] q[$];
  bit          m_ovf  = 0;
  bit          m_act  = 0;
  int          m_done = 0;

  always #5 clk = ~clk;

  result_collector #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .y        (y),
    .s        (s),
    .b        (b),
    .regime   (regime),
    .active   (active),
    .r_valid  (r_valid),
    .r_ready  (r_ready),
    .r_data   (r_data),
    .count    (count),
    .full     (full),
    .overflow (overflow),
`ifdef RESULT_COLLECTOR_COUNT_EN
    .done_cnt (done_cnt),
`endif
    .clr_ovf  (clr_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every observable output with the model.
  task automatic check_model();
    chk("r_valid",  32'(r_valid),  32'(q.size() != 0));
    chk("count",    32'(count),    32'(q.size()));
    chk("full",     32'(full),     32'(q.size() == DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (q.size() != 0) chk("r_data", 32'(r_data), 32'(q[0]));
`ifdef RESULT_COLLECTOR_COUNT_EN
    chk("done_cnt", 32'(done_cnt), 32'(m_done));
`endif
  endtask

  // Advance one clock: update the model from the current inputs, then
  // sample the DUT 1 time unit after the edge.
  task automatic tick();
    bit comp, pop, dropped;
    logic [13:0] tmp;
    if (rst) begin
      q.delete();
      m_ovf  = 0;
      m_act  = 0;
      m_done = 0;
    end else begin
      comp    = m_act && !active;
      pop     = (q.size() != 0) && r_ready;
      dropped = 0;
      if (pop) tmp = q.pop_front();
      if (comp) begin
        if (m_done < 255) m_done++;
        if (q.size() < DEPTH) q.push_back({regime, b, s, y});
        else dropped = 1;
      end
      if (dropped) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
      m_act = active;
    end
    @(posedge clk);
    #1;
    check_model();
    $display("cycle rst=%0b act=%0b rdy=%0b valid=%0b data=%h count=%0d full=%0b ovf=%0b",
             rst, active, r_ready, r_valid, r_data, count, full, overflow);
  endtask

  // One operation: a busy cycle then the falling cycle carrying the result.
  task automatic complete(input logic [7:0] yy, input logic [2:0] ss,
                          input logic bb, input logic [1:0] rr);
    active = 1'b1;
    tick();
    y = yy; s = ss; b = bb; regime = rr;
    active = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; active = 1'b0; r_ready = 1'b0; clr_ovf = 1'b0;
    y = '0; s = '0; b = 1'b0; regime = '0;

    // Reset then idle
    tick(); tick();
    chk("reset_r_valid",  32'(r_valid),  32'd0);
    chk("reset_r_data",   32'(r_data),   32'd0);
    chk("reset_count",    32'(count),    32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    // Single result
    active = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    y = 8'hA5; s = 3'd3; b = 1'b1; regime = 2'd2; active = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("single_valid", 32'(r_valid), 32'd1);
      chk("single_data",  32'(r_data),  32'h2BA5);
      chk("single_count", 32'(count),   32'd1);
      y = 8'(i); tick();
    end
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    chk("single_pop_valid", 32'(r_valid), 32'd0);
    chk("single_pop_count", 32'(count),   32'd0);

    // Fill and overflow
    for (int i = 1; i <= 5; i++) begin
      complete(8'(i), 3'(i), 1'b0, 2'd1);
      if (i == 4) chk("fill_full_4th", 32'(full), 32'd1);
      if (i == 4) chk("fill_ovf_4th",  32'(overflow), 32'd0);
    end
    chk("fill_ovf_5th", 32'(overflow), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_order", 32'(r_data[7:0]), 32'(i));
      r_ready = 1'b1; tick(); r_ready = 1'b0;
    end
    chk("drain_empty", 32'(r_valid), 32'd0);
    chk("drain_ovf_sticky", 32'(overflow), 32'd1);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    chk("clr_ovf", 32'(overflow), 32'd0);

    // Simultaneous push/pop while full
    for (int i = 0; i < 4; i++) complete(8'(8'd10 + 8'(i)), 3'd0, 1'b0, 2'd0);
    chk("sim_full", 32'(full), 32'd1);
    active = 1'b1; tick();
    y = 8'd14; active = 1'b0; r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    chk("sim_count", 32'(count),    32'd4);
    chk("sim_ovf",   32'(overflow), 32'd0);
    for (int i = 11; i <= 14; i++) begin
      chk("sim_drain_order", 32'(r_data[7:0]), 32'(i));
      r_ready = 1'b1; tick(); r_ready = 1'b0;
    end

    // Wrap-around with continuous drain
    r_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      complete(8'(8'h40 + 8'(i)), 3'(i), 1'(i), 2'(i));
      chk("wrap_count_le1", 32'(count <= 3'd1), 32'd1);
      chk("wrap_head", 32'(r_data[7:0]), 32'(8'h40 + 8'(i)));
    end
    tick();
    r_ready = 1'b0;
    chk("wrap_empty", 32'(r_valid), 32'd0);

    // Reset mid-operation
    for (int i = 0; i < 3; i++) complete(8'(i), 3'd1, 1'b1, 2'd3);
    active = 1'b1; tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_count", 32'(count),   32'd0);
    chk("midrst_valid", 32'(r_valid), 32'd0);
`ifdef RESULT_COLLECTOR_COUNT_EN
    chk("midrst_done_cnt", 32'(done_cnt), 32'd0);
`endif
    // active_d is 0 after reset, so this low level is not a completion
    active = 1'b0; tick();
    chk("post_rst_no_comp", 32'(count), 32'd0);

`ifdef RESULT_COLLECTOR_COUNT_EN
    r_ready = 1'b1;
    for (int i = 0; i < 300; i++) complete(8'(i), 3'd0, 1'b0, 2'd0);
    chk("done_cnt_sat", 32'(done_cnt), 32'd255);
    r_ready = 1'b0;
`endif

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      active  = 1'($urandom_range(0, 1));
      r_ready = ($urandom_range(0, 3) == 0);
      clr_ovf = ($urandom_range(0, 9) == 0);
      rst     = ($urandom_range(0, 149) == 0);
      y       = 8'($urandom);
      s       = 3'($urandom);
      b       = 1'($urandom);
      regime  = 2'($urandom);
      tick();
    end
    rst = 1'b0; clr_ovf = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
